serial_rx_ctrl: RTL
===================

SERIAL_RX_CTRL -- requirements
Module: serial_rx_ctrl

Interface
REQ-001 SHALL have parameter NUM_BITS, default 8, data bits per frame (2..32).
REQ-002 SHALL have parameter BIT_PERIOD, default 10, clk cycles per serial bit (even, >= 4); HALF = BIT_PERIOD/2.
REQ-003 SHALL have port clk  input  1  system clock, rising-edge active.
REQ-004 SHALL have port n_rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port serial_in  input  1  line data, already synchronized, idle high.
REQ-006 SHALL have port data_read  input  1  consumer acknowledges the buffered word.
REQ-007 SHALL have port shift_enable  output  1  one-cycle pulse to the serial-to-parallel shift register.
REQ-008 SHALL have port load_buffer  output  1  one-cycle pulse to copy parallel_out into the holding buffer.
REQ-009 SHALL have port data_ready  output  1  holding buffer contains unread data.
REQ-010 SHALL have port framing_error  output  1  last frame had stop bit = 0.
REQ-011 SHALL have port overrun_error  output  1  a word was overwritten before data_read.
REQ-012 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-013 SHALL implement states IDLE, START, DATA, STOP, LOAD.
REQ-014 IDLE SHALL register serial_in each cycle. T0 is the cycle in which the previous sample is 1 and the current is 0. The FSM SHALL go to START at T0+1, and SHALL clear framing_error at T0+1.
REQ-015 START SHALL sample serial_in at T0+HALF: 0 -> DATA with timer and bit count cleared; 1 (glitch) -> IDLE, no pulses.
REQ-016 DATA SHALL assert shift_enable for exactly one cycle at T0+HALF+k*BIT_PERIOD for k = 1..NUM_BITS, i.e. at mid-bit.
REQ-017 After the NUM_BITS-th pulse the FSM SHALL enter STOP. No shift_enable SHALL occur outside DATA.
REQ-018 STOP SHALL sample serial_in at T0+HALF+(NUM_BITS+1)*BIT_PERIOD.
REQ-019 On stop = 1 the FSM SHALL go to LOAD. On stop = 0 it SHALL set framing_error and go to IDLE without load_buffer.
REQ-020 LOAD SHALL assert load_buffer for one cycle (stop-sample cycle + 1) and then return to IDLE.
REQ-021 data_ready SHALL be 1 from the cycle after load_buffer until the cycle after data_read; data_read while data_ready = 0 SHALL be ignored.
REQ-022 If load_buffer occurs while data_ready = 1 and data_read is not asserted that cycle, overrun_error SHALL be set.
REQ-023 data_read coincident with load_buffer SHALL leave data_ready = 1 and SHALL NOT set overrun_error (load wins).
REQ-024 overrun_error SHALL clear on data_read. Clear and set in the same cycle is impossible by REQ-023.
REQ-025 A falling edge during STOP or LOAD SHALL NOT start a frame. Detection SHALL resume in IDLE, requiring a fresh 1->0 sample pair.
REQ-026 The bit-timer width SHALL be $clog2(BIT_PERIOD+1); the bit-count width SHALL be $clog2(NUM_BITS+1); neither SHALL wrap mid-frame.

Reset
REQ-027 n_rst low SHALL force IDLE asynchronously, including mid-frame; no pulse SHALL be emitted for the aborted frame.
REQ-028 n_rst low SHALL force shift_enable = 0, load_buffer = 0, data_ready = 0, framing_error = 0, overrun_error = 0, busy = 0.
REQ-029 n_rst low SHALL clear the timer and bit count, and SHALL set the edge-detect register to 1 so that no false start occurs after reset.

Structure
REQ-030 The state enum type rx_state_t SHALL live in shared package rx_ctrl_pkg. NUM_BITS/BIT_PERIOD-derived constants SHALL be local.
REQ-031 The bit timer SHALL be one instance of sub-module flex_counter: clear, count_enable, rollover_val, count_out, rollover_flag; rollover_val is HALF in START and BIT_PERIOD otherwise.
REQ-032 The bit count SHALL be a local counter in serial_rx_ctrl. Outputs SHALL be registered or decoded from state only, never from serial_in.

Verification (NUM_BITS = 8, BIT_PERIOD = 10)
REQ-033 Valid frame, start edge at T0, 8 data bits, stop = 1 -> shift_enable at T0+15, 25, ..., 85; load_buffer at T0+96; data_ready = 1 at T0+97; busy low at T0+97.
REQ-034 serial_in low for 3 cycles from T0 -> no shift_enable, no load_buffer; IDLE by T0+6; busy 0.
REQ-035 Frame with stop bit = 0 -> 8 shift_enable pulses, no load_buffer, framing_error = 1 at T0+96 and cleared by the next start edge.
REQ-036 Two valid frames, no data_read -> overrun_error = 1 after the second load_buffer; data_read -> data_ready = 0 and overrun_error = 0 next cycle.
REQ-037 data_read asserted exactly on the second load_buffer cycle -> data_ready stays 1 and overrun_error stays 0.
REQ-038 n_rst pulsed after the 4th shift_enable -> all outputs 0 immediately; a following valid frame produces exactly 8 pulses and one load_buffer.

Source files
------------

// File: rtl/rx_ctrl_pkg.sv
// Shared types for the serial receive controller.
package rx_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    LOAD
  } rx_state_t;

endpackage

// File: rtl/flex_counter.sv
// Bit timer: counts enabled cycles from zero and flags the cycle that completes
// a period of rollover_val cycles, restarting from zero on that cycle.
module flex_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             clear,
  input  logic             count_enable,
  input  logic [WIDTH-1:0] rollover_val,
  output logic [WIDTH-1:0] count_out,
  output logic             rollover_flag
);

  assign rollover_flag = count_enable && (count_out == rollover_val - WIDTH'(1));

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)             count_out <= '0;
    else if (clear)         count_out <= '0;
    else if (rollover_flag) count_out <= '0;
    else if (count_enable)  count_out <= count_out + WIDTH'(1);
  end

endmodule

// File: rtl/serial_rx_ctrl.sv
// Receive sequencing for an idle-high serial line: start detection, mid-bit
// shift strobes, stop-bit check, buffer load and ready/overrun/framing status.
module serial_rx_ctrl
  import rx_ctrl_pkg::*;
#(
  parameter int NUM_BITS   = 8,
  parameter int BIT_PERIOD = 10
) (
  input  logic clk,
  input  logic n_rst,
  input  logic serial_in,
  input  logic data_read,
  output logic shift_enable,
  output logic load_buffer,
  output logic data_ready,
  output logic framing_error,
  output logic overrun_error,
  output logic busy
);

  // state | meaning
  // IDLE  | watching for a 1->0 sample pair on the line
  // START | waiting half a bit to confirm the start bit
  // DATA  | one shift strobe per bit period, at mid-bit
  // STOP  | sampling the stop bit at mid-bit
  // LOAD  | one-cycle buffer load, then back to IDLE

  localparam int HALF = BIT_PERIOD / 2;
  localparam int TW   = $clog2(BIT_PERIOD + 1);
  localparam int CW   = $clog2(NUM_BITS + 1);

  rx_state_t      state, next_state;
  logic           prev_in;
  logic [CW-1:0]  bit_cnt;
  logic [TW-1:0]  timer_count;
  logic [TW-1:0]  rollover_val;
  logic           timer_flag, timer_clear, timer_en;
  logic           cnt_clr, cnt_inc, set_fe, clr_fe;

  assign rollover_val = (state == START) ? TW'(HALF) : TW'(BIT_PERIOD);

  flex_counter #(.WIDTH(TW)) u_bit_timer (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (timer_clear),
    .count_enable (timer_en),
    .rollover_val (rollover_val),
    .count_out    (timer_count),
    .rollover_flag(timer_flag)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state   = state;
    shift_enable = 1'b0;
    load_buffer  = 1'b0;
    timer_clear  = 1'b0;
    timer_en     = 1'b0;
    cnt_clr      = 1'b0;
    cnt_inc      = 1'b0;
    set_fe       = 1'b0;
    clr_fe       = 1'b0;
    case (state)
      IDLE: begin
        timer_clear = 1'b1;
        cnt_clr     = 1'b1;
        if (prev_in && !serial_in) begin
          next_state = START;
          clr_fe     = 1'b1;
        end
      end
      START: begin
        timer_en = 1'b1;
        if (timer_flag) begin
          if (!serial_in) begin
            next_state  = DATA;
            timer_clear = 1'b1;
            cnt_clr     = 1'b1;
          end else begin
            next_state = IDLE;
          end
        end
      end
      DATA: begin
        timer_en = 1'b1;
        if (timer_flag) begin
          shift_enable = 1'b1;
          if (bit_cnt == CW'(NUM_BITS - 1)) begin
            next_state = STOP;
            cnt_clr    = 1'b1;
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
      STOP: begin
        timer_en = 1'b1;
        if (timer_flag) begin
          if (serial_in) begin
            next_state = LOAD;
          end else begin
            next_state = IDLE;
            set_fe     = 1'b1;
          end
        end
      end
      LOAD: begin
        load_buffer = 1'b1;
        next_state  = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // Outside IDLE the history is forced low so a new start needs two IDLE samples.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) prev_in <= 1'b1;
    else        prev_in <= (state == IDLE) ? serial_in : 1'b0;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)       bit_cnt <= '0;
    else if (cnt_clr) bit_cnt <= '0;
    else if (cnt_inc) bit_cnt <= bit_cnt + CW'(1);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      data_ready    <= 1'b0;
      overrun_error <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      if (load_buffer)    data_ready <= 1'b1;
      else if (data_read) data_ready <= 1'b0;

      if (data_read && data_ready)        overrun_error <= 1'b0;
      else if (load_buffer && data_ready) overrun_error <= 1'b1;

      if (clr_fe)      framing_error <= 1'b0;
      else if (set_fe) framing_error <= 1'b1;
    end
  end

  a_timer_in_range: assert property (@(posedge clk) disable iff (!n_rst)
    timer_count < TW'(BIT_PERIOD));

endmodule
